// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand type, fmul pipeline depth and the tag
// record that travels alongside each shared-unit operation.
package fpu_pkg;

    localparam int unsigned FP32_W       = 32;
    localparam int unsigned FMUL_LATENCY = 2;
    // Tag id is sized for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W     = 3;

    typedef logic [FP32_W-1:0] fp32_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } fmul_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after ptr,
// searching upward with wrap. Shared by the fmul/fadd/fdiv front ends.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % N_REQ);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmul_arbiter.sv
// Shares one fully pipelined fmul between N_REQ requesters: round-robin
// issue, requester tags shifted alongside the fmul, results steered home.
module fmul_arbiter
    import fpu_pkg::*;
#(
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned LATENCY = FMUL_LATENCY,
    parameter  int unsigned ID_W    = $clog2(N_REQ),
    localparam int unsigned CNT_W   = $clog2(LATENCY + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FP32_W-1:0] req_x1,
    input  logic [N_REQ*FP32_W-1:0] req_x2,
    output logic [N_REQ-1:0]        req_ready,
    output fp32_t                   fmul_x1,
    output fp32_t                   fmul_x2,
    input  fp32_t                   fmul_y,
    input  logic                    fmul_ovf,
    output logic [N_REQ-1:0]        resp_valid,
    output fp32_t                   resp_y,
    output logic                    resp_ovf,
    output logic [ID_W-1:0]         resp_id,
    output logic [CNT_W-1:0]        in_flight,
    output logic                    busy
);

    logic [ID_W-1:0]  r_rr_ptr;
    fp32_t            r_x1;
    fp32_t            r_x2;
    fmul_tag_t        r_tag [LATENCY+1];
    logic [CNT_W-1:0] r_in_flight;

    logic             w_arb_en;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_id;
    logic             w_hs;
    fp32_t            w_sel_x1;
    fp32_t            w_sel_x2;
    fmul_tag_t        w_last;

    // No grants while held or while reset is applied.
    assign w_arb_en = !hold && !rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .en       (w_arb_en),
        .ptr      (r_rr_ptr),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    // Grant only ever covers valid requesters, so any grant is a handshake.
    assign w_hs = |w_grant;

    always_comb begin
        w_sel_x1 = '0;
        w_sel_x2 = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_sel_x1 = w_sel_x1 | (req_x1[i*FP32_W +: FP32_W] & {FP32_W{w_grant[i]}});
            w_sel_x2 = w_sel_x2 | (req_x2[i*FP32_W +: FP32_W] & {FP32_W{w_grant[i]}});
        end
    end

    assign w_last = r_tag[LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= ID_W'(N_REQ - 1);
            r_x1        <= '0;
            r_x2        <= '0;
            r_in_flight <= '0;
            for (int unsigned k = 0; k <= LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            if (w_hs) begin
                r_rr_ptr <= w_grant_id;
            end
            // Idle cycles present zero operands to the fmul.
            r_x1           <= w_hs ? w_sel_x1 : '0;
            r_x2           <= w_hs ? w_sel_x2 : '0;
            r_tag[0].valid <= w_hs;
            r_tag[0].id    <= TAG_ID_W'(w_grant_id);
            for (int unsigned k = 1; k <= LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            case ({w_hs, w_last.valid})
                2'b10:   r_in_flight <= r_in_flight + CNT_W'(1);
                2'b01:   r_in_flight <= r_in_flight - CNT_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            resp_valid[i] = w_last.valid && (w_last.id == TAG_ID_W'(i));
        end
    end

    assign req_ready = w_grant;
    assign fmul_x1   = r_x1;
    assign fmul_x2   = r_x2;
    assign resp_y    = fmul_y;
    assign resp_ovf  = fmul_ovf;
    assign resp_id   = ID_W'(w_last.id);
    assign in_flight = r_in_flight;
    assign busy      = (r_in_flight != '0);

endmodule

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
Shares one pipelined fmul unit between N_REQ requesters, such as core issue slots and the FPU load/convert sequencer.
Uses round-robin arbitration with a valid/ready handshake per requester, and issues at most one multiply per cycle.
Tags each issued operation with its requester index, tracking it down a shift pipe whose length matches the fmul latency.
Routes each result and its overflow flag back to the owning requester.

Parameters:
N_REQ, 4, number of requesters (2..8)
LATENCY, 2, fmul cycles from operands applied to y/ovf valid (fixed, fully pipelined)
ID_W, $clog2(N_REQ), width of requester tag

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
hold  in  1  when 1, no new grants (used while the FPU is reconfigured); in-flight ops still complete
req_valid  in  N_REQ  requester i has an operation
req_x1  in  N_REQ*32  operand 1 of requester i, at bits [32i+31:32i]
req_x2  in  N_REQ*32  operand 2, same packing
req_ready  out  N_REQ  one-hot grant; handshake when req_valid[i] and req_ready[i]
fmul_x1  out  32  operand 1 to fmul (registered)
fmul_x2  out  32  operand 2 to fmul (registered)
fmul_y  in  32  fmul result
fmul_ovf  in  1  fmul overflow flag
resp_valid  out  N_REQ  one-hot pulse: result for requester i
resp_y  out  32  result (fmul_y passthrough)
resp_ovf  out  1  overflow (fmul_ovf passthrough)
resp_id  out  ID_W  tag of the current result
in_flight  out  $clog2(LATENCY+2)  number of ops issued but not yet returned
busy  out  1  in_flight != 0

Behaviour:
- Reset values:
  - req_ready=0, fmul_x1=fmul_x2=0, resp_valid=0, resp_id=0, in_flight=0, busy=0.
  - rr_ptr=N_REQ-1, so requester 0 has first priority.
  - All tag-pipe valid bits are 0.
- Arbitration (combinational in cycle t):
  - If hold=0, grant the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - req_ready is one-hot for the granted i, otherwise all zero.
  - req_ready never asserts for a requester with req_valid=0.
- rr_ptr is updated to the granted index only on a handshake; it wraps from N_REQ-1 to 0.
- Issue register: on a handshake at edge t, fmul_x1/fmul_x2 load the granted operands for cycle t+1.
  - With no handshake, they load 0 (deterministic idle operands).
- Tag pipe: LATENCY+1 stages of {valid, id}.
  - Stage 0 loads {handshake, granted id} at the same edge as the issue register.
  - Each later stage shifts every cycle; the pipe never stalls.
- Response (combinational from the last stage):
  - resp_valid[id]=last.valid; resp_id=last.id; resp_y=fmul_y; resp_ovf=fmul_ovf.
  - resp_valid=0 when last.valid=0; resp_y/resp_ovf are don't-care then.
- Latency: a handshake in cycle t gives resp_valid in cycle t+1+LATENCY (3 cycles by default).
  - Throughput is one op per cycle, and responses return in issue order.
- Responses have no backpressure: requesters must accept resp_valid in the cycle it is asserted.
- in_flight: +1 on handshake, -1 on last.valid; both in one cycle gives no change.
  - Maximum value is LATENCY+1, with no overflow.
- hold rising mid-stream: grants stop in the same cycle, and the tag pipe drains normally. busy falls after the last response.
- A request that drops req_valid without a handshake is simply not granted; no state changes.
- rst mid-operation:
  - All tags are cleared at once, so in-flight results are dropped and no resp_valid is produced.
  - rr_ptr returns to N_REQ-1.
  - fmul is reset by the top level with the same reset.
- Simultaneous valid on all requesters: each is served once every N_REQ cycles, so no starvation.

Decomposition:
- Shared package fpu_pkg:
  - FP32 width constant (32);
  - FMUL_LATENCY constant, which is the source for the LATENCY default;
  - typedef fp32_t;
  - typedef fmul_tag_t {valid, id}.
- One natural sub-module: rr_arbiter (N_REQ-wide round-robin, inputs req/en/ptr, output one-hot grant), reusable for fadd/fdiv sharing.

Test Plan:
- Single request: req0 x1=0x3FC00000 (1.5), x2=0x40000000 (2.0) at cycle 5.
  - Expect req_ready[0] in cycle 5 and fmul_x1/x2 in cycle 6.
  - Expect resp_valid=0001, resp_y=0x40400000, resp_id=0, resp_ovf=0 in cycle 8.
  - busy is high in cycles 6-8.
- All four requesters valid continuously after reset:
  - Grants are 0,1,2,3,0,... in consecutive cycles.
  - Responses have ids 0,1,2,3 in cycles t+3..t+6, and in_flight saturates at 3.
  - Operands are 0x3F800000 (1.0) times distinct values; each y equals the requester's x2.
- Overflow routing: req2 x1=x2=0x7F000000 -> resp_valid=0100, resp_y=0x7F800000, resp_ovf=1.
- hold asserted for 4 cycles while req1 is valid:
  - req_ready stays 0 throughout.
  - The prior in-flight op still returns.
  - req1 is granted in the first cycle after hold falls.
- Reset mid-stream: assert rst one cycle after two handshakes.
  - No resp_valid follows, in_flight=0 immediately, and the next grant goes to requester 0.
- Round-robin fairness: req3 issues, then req1 and req3 are both valid.
  - Expect grant to req1 first (pointer 3 wraps to 0), then req3.
